column_renderer: RTL and testbench
==================================

# column_renderer

Pixel-generation stage directly downstream of the VGA timing generator. Holds one frame of per-column wall slices (height and colour) produced by the raycaster in a ping-pong column buffer, then converts the timing generator's pixel_x/pixel_y/video_on stream into 12-bit RGB as ceiling, wall or floor. It also delays hsync/vsync so they stay aligned with the RGB stream. Buffers swap only at vertical retrace, so a frame is never torn.

## Interface
- NCOL, 160: columns per frame; each column is 2^COLW_LOG2 pixels wide.
- COLW_LOG2, 2: log2 of the column width in pixels.
- CEIL_RGB, 12'h222: ceiling colour.
- FLOOR_RGB, 12'h555: floor colour.
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- p_tick  in  1  pixel enable from the timing generator; high every other clk.
- video_on  in  1  visible-area flag.
- hsync_in  in  1  horizontal sync, active-high during retrace.
- vsync_in  in  1  vertical sync, active-high during retrace.
- pixel_x  in  10  current column count.
- pixel_y  in  10  current row count.
- col_valid  in  1  upstream slice valid.
- col_ready  out  1  slice accepted when col_valid && col_ready.
- col_height  in  9  wall height in rows (0..511).
- col_color  in  12  wall RGB for the slice.
- rgb  out  12  pixel colour, 4:4:4.
- hsync  out  1  hsync_in delayed by 2 p_ticks.
- vsync  out  1  vsync_in delayed by 2 p_ticks.
- frame_start  out  1  one-clk pulse when the banks swap.

## Operation
- Two banks, each NCOL × 21 bits (height and colour). Register wsel selects the write bank; the display bank is !wsel.
- Write side, clk domain, independent of p_tick:
  - On an accepted slice, write to address wr_ptr in bank wsel, then wr_ptr++.
  - When wr_ptr reaches NCOL, set the full flag and deassert col_ready.
  - col_ready = !full. Slices are accepted in column order 0..NCOL-1.
- Swap detection:
  - On each p_tick cycle, register vsync_in into vs_prev.
  - A rising edge is vsync_in && !vs_prev on a p_tick cycle.
  - On a rising edge with full already registered high: toggle wsel, clear wr_ptr and full, set frame_valid, pulse frame_start for one clk.
  - On a rising edge with full low: no swap. The display bank keeps showing the previous frame and writes continue.
  - If the final write lands in the same clk as the edge, full is not yet set, so the swap waits for the next frame.
- Render pipeline advances only on p_tick:
  - S1: col = pixel_x >> COLW_LOG2. Synchronous read from the display bank at col, only when video_on; otherwise the address is held. Register pixel_y, video_on, hsync_in and vsync_in.
  - S2: h = min(height, 480); half = h >> 1; top = 240 − half; bot = 240 + half (10-bit unsigned).
    - y < top → CEIL_RGB.
    - top ≤ y < bot → wall colour.
    - otherwise → FLOOR_RGB.
    - Odd heights drop one row.
  - rgb is forced to 12'h000 when the delayed video_on is low or frame_valid is low.
- An index with col ≥ NCOL cannot occur during video_on (640 / 4 = 160). No bound check is required.

## Timing
- Reset values:
  - rgb = 0, hsync = 0, vsync = 0, frame_start = 0, col_ready = 1.
  - wsel = 0, wr_ptr = 0, full = 0, frame_valid = 0, vs_prev = 0.
  - Buffer RAM contents are not reset.
- Pipeline latency is exactly 2 p_ticks (4 clk) from pixel_x/pixel_y/syncs to rgb/hsync/vsync. All outputs change only on clk edges where p_tick = 1.
- Write throughput is 1 slice/clk. col_ready falls in the clk after the NCOL-th accept.
- frame_start is high for 1 clk. wsel changes in the same edge, and col_ready returns high in that same edge.
- Reset mid-frame discards the partial write frame and blanks the output until the next completed swap.

## Test plan
- Reset, then run 2 full frames with no writes → rgb = 0 throughout, col_ready = 1, no frame_start, hsync/vsync equal the inputs delayed by 4 clk.
- Write 160 slices of height 100 and colour 12'hF00, then cross a vsync edge → one frame_start pulse. On the next frame:
  - rows 0–189 → 12'h222
  - rows 190–289 → 12'hF00
  - rows 290–479 → 12'h555
- Slice 5 with height 511 → rows 0–479 at pixel_x 20–23 show the wall colour (height clamped to 480). Slice 6 with height 0 → no wall rows. Slice 7 with height 3 → rows 239–240 only.
- Complete only 100 writes before the vsync edge → no swap, the previous frame is still displayed, col_ready stays 1. Finish the 160 writes → swap occurs on the next edge.
- Hold col_valid high for 200 clk → exactly 160 accepts. col_ready = 0 from the clk after the 160th accept until frame_start.
- Assert reset mid-frame during writes → all outputs return to their reset values immediately. After reset, one full write plus a vsync edge restores the image.

Source files
------------

// File: rtl/column_renderer_if.sv
// Column-slice stream from the raycaster into the column renderer.
interface column_renderer_if;
  logic        col_valid;
  logic        col_ready;
  logic [8:0]  col_height;
  logic [11:0] col_color;

  modport master (output col_valid, output col_height, output col_color, input col_ready);
  modport slave  (input col_valid, input col_height, input col_color, output col_ready);
endinterface

// File: rtl/column_renderer.sv
// Ping-pong column buffer plus a two-stage render pipeline that turns
// pixel_x/pixel_y into ceiling/wall/floor RGB and delays the syncs to match.
module column_renderer #(
  parameter int          NCOL      = 160,
  parameter int          COLW_LOG2 = 2,
  parameter logic [11:0] CEIL_RGB  = 12'h222,
  parameter logic [11:0] FLOOR_RGB = 12'h555
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p_tick,
  input  logic                video_on,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  column_renderer_if.slave    col,
  output logic [11:0]         rgb,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start
);

  localparam int AW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [AW-1:0] LAST = AW'(NCOL - 1);

  logic [20:0]   bank0 [NCOL];
  logic [20:0]   bank1 [NCOL];

  logic          wsel;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          frame_valid;
  logic          vs_prev;

  logic          wr_en;
  logic          swap;
  logic [AW-1:0] rd_addr;

  logic [20:0]   rd_data;
  logic [9:0]    y1;
  logic          vid1;
  logic          hs1;
  logic          vs1;

  logic [9:0]    h_clamp;
  logic [9:0]    half;
  logic [9:0]    top;
  logic [9:0]    bot;
  logic [11:0]   pix_next;

  assign col.col_ready = ~full;
  assign wr_en   = col.col_valid && !full;
  // full is the registered flag, so a final write coinciding with the edge defers the swap
  assign swap    = p_tick && vsync_in && !vs_prev && full;
  assign rd_addr = pixel_x[COLW_LOG2 +: AW];

  // Buffer storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !wsel) bank0[wr_ptr] <= {col.col_height, col.col_color};
    if (wr_en &&  wsel) bank1[wr_ptr] <= {col.col_height, col.col_color};
    if (p_tick && video_on) rd_data <= wsel ? bank0[rd_addr] : bank1[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wsel        <= 1'b0;
      wr_ptr      <= '0;
      full        <= 1'b0;
      frame_valid <= 1'b0;
      vs_prev     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) vs_prev <= vsync_in;
      if (swap) begin
        wsel        <= ~wsel;
        wr_ptr      <= '0;
        full        <= 1'b0;
        frame_valid <= 1'b1;
        frame_start <= 1'b1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == LAST) full <= 1'b1;
      end
    end
  end

  always_comb begin
    h_clamp  = ({1'b0, rd_data[20:12]} > 10'd480) ? 10'd480 : {1'b0, rd_data[20:12]};
    half     = h_clamp >> 1;
    top      = 10'd240 - half;
    bot      = 10'd240 + half;
    pix_next = '0;
    if (vid1 && frame_valid) begin
      if (y1 < top)      pix_next = CEIL_RGB;
      else if (y1 < bot) pix_next = rd_data[11:0];
      else               pix_next = FLOOR_RGB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y1    <= '0;
      vid1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      y1    <= pixel_y;
      vid1  <= video_on;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
      rgb   <= pix_next;
      hsync <= hs1;
      vsync <= vs1;
    end
  end

endmodule

// File: tb/tb_column_renderer.sv
// Bench for column_renderer: scoreboard on the render stream, table of slice-shape vectors.
module tb_column_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  column_renderer_if col_bus();

  column_renderer #(
    .NCOL(160), .COLW_LOG2(2), .CEIL_RGB(12'h222), .FLOOR_RGB(12'h555)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .col(col_bus), .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) p_tick <= ~p_tick;

  int checks = 0;
  int errors = 0;
  int fs_count = 0;

  always @(negedge clk) if (frame_start === 1'b1) fs_count++;

  typedef struct { logic [11:0] rgb; logic hs; logic vs; } out_t;
  typedef struct { int x; int y; logic [11:0] rgb; } vec_t;

  out_t sb[$];

  logic [8:0]  src_h [160];
  logic [11:0] src_c [160];
  logic [8:0]  wb_h  [160];
  logic [11:0] wb_c  [160];
  logic [8:0]  db_h  [160];
  logic [11:0] db_c  [160];
  int wcnt = 0;
  bit m_valid = 0;
  bit m_vs_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] expect_pix(input int x, input int y, input bit von);
    int c, h, half;
    if (!von || !m_valid) return 12'h000;
    c = x / 4;
    h = (int'(db_h[c]) > 480) ? 480 : int'(db_h[c]);
    half = h / 2;
    if (y < 240 - half) return 12'h222;
    if (y < 240 + half) return db_c[c];
    return 12'h555;
  endfunction

  // One pixel step: driven so the next p_tick edge captures it; output lags one step.
  task automatic pix(input int x, input int y, input bit von, input bit hs, input bit vs);
    out_t e;
    do @(negedge clk); while (!p_tick);
    pixel_x = 10'(x); pixel_y = 10'(y);
    video_on = von; hsync_in = hs; vsync_in = vs;
    if (vs && !m_vs_prev && wcnt == 160) begin
      db_h = wb_h; db_c = wb_c; m_valid = 1; wcnt = 0;
    end
    m_vs_prev = vs;
    e.rgb = expect_pix(x, y, von);
    e.hs = hs;
    e.vs = vs;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("rgb", rgb, e.rgb);
      check("hsync", hsync, e.hs);
      check("vsync", vsync, e.vs);
    end
  endtask

  task automatic vsync_edge();
    pix(0, 480, 0, 0, 0);
    pix(0, 490, 0, 0, 1);
    pix(0, 491, 0, 0, 1);
    pix(0, 492, 0, 0, 0);
  endtask

  task automatic scan(input int x, input int y0, input int y1, input int stp);
    for (int y = y0; y <= y1; y += stp) begin
      pix(x, y, 1, 0, 0);
      pix(x, y, 0, 1, 0);
    end
  endtask

  task automatic write_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("col_ready_during_write", col_bus.col_ready, 1);
      col_bus.col_valid  = 1'b1;
      col_bus.col_height = src_h[wcnt];
      col_bus.col_color  = src_c[wcnt];
      @(posedge clk);
      wb_h[wcnt] = src_h[wcnt];
      wb_c[wcnt] = src_c[wcnt];
      wcnt++;
    end
    @(negedge clk);
    col_bus.col_valid = 1'b0;
  endtask

  task automatic fill_src(input logic [8:0] h, input logic [11:0] c);
    for (int i = 0; i < 160; i++) begin
      src_h[i] = h;
      src_c[i] = c;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int acc;
    bit rdy;

    tbl[0]  = '{20,   0, 12'h0F0};
    tbl[1]  = '{21, 240, 12'h0F0};
    tbl[2]  = '{23, 479, 12'h0F0};
    tbl[3]  = '{24,   0, 12'h222};
    tbl[4]  = '{25, 239, 12'h222};
    tbl[5]  = '{27, 240, 12'h555};
    tbl[6]  = '{27, 479, 12'h555};
    tbl[7]  = '{28, 238, 12'h222};
    tbl[8]  = '{29, 239, 12'h0FF};
    tbl[9]  = '{30, 240, 12'h0FF};
    tbl[10] = '{31, 241, 12'h555};
    tbl[11] = '{19, 189, 12'h222};
    tbl[12] = '{19, 190, 12'hF00};
    tbl[13] = '{19, 289, 12'hF00};
    tbl[14] = '{32, 290, 12'h555};
    tbl[15] = '{639, 100, 12'h222};

    col_bus.col_valid  = 1'b0;
    col_bus.col_height = '0;
    col_bus.col_color  = '0;
    fill_src(9'd0, 12'h000);

    // Reset state
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rgb", rgb, 0);
    check("reset_hsync", hsync, 0);
    check("reset_vsync", vsync, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_col_ready", col_bus.col_ready, 1);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    reset = 1'b0;

    // Two frames with no writes: output stays blank, no swap
    vsync_edge();
    scan(100, 0, 479, 37);
    vsync_edge();
    scan(400, 5, 479, 53);
    check("no_frame_start", fs_count, 0);
    check("idle_col_ready", col_bus.col_ready, 1);

    // Full frame of height 100 red
    fill_src(9'd100, 12'hF00);
    write_n(160);
    check("ready_low_when_full", col_bus.col_ready, 0);
    vsync_edge();
    check("first_swap", fs_count, 1);
    check("ready_after_swap", col_bus.col_ready, 1);
    scan(0, 0, 479, 1);
    scan(637, 0, 479, 3);

    // Partial frame: no swap until complete
    fill_src(9'd200, 12'h0F0);
    write_n(100);
    vsync_edge();
    check("partial_no_swap", fs_count, 1);
    check("partial_col_ready", col_bus.col_ready, 1);
    scan(321, 0, 479, 7);
    write_n(60);
    vsync_edge();
    check("completed_swap", fs_count, 2);
    scan(321, 0, 479, 1);

    // Held col_valid: exactly 160 accepts, ready low until the swap
    fill_src(9'd100, 12'hF00);
    src_h[5] = 9'd511; src_c[5] = 12'h0F0;
    src_h[6] = 9'd0;   src_c[6] = 12'h00F;
    src_h[7] = 9'd3;   src_c[7] = 12'h0FF;
    acc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc >= 160) check("ready_low_after_full", col_bus.col_ready, 0);
      col_bus.col_valid  = 1'b1;
      col_bus.col_height = src_h[(acc < 160) ? acc : 0];
      col_bus.col_color  = src_c[(acc < 160) ? acc : 0];
      rdy = col_bus.col_ready;
      @(posedge clk);
      if (rdy) begin
        if (acc < 160) begin
          wb_h[acc] = src_h[acc];
          wb_c[acc] = src_c[acc];
        end
        acc++;
      end
    end
    @(negedge clk);
    col_bus.col_valid = 1'b0;
    check("accept_count", acc, 160);
    wcnt = (acc > 160) ? 160 : acc;
    check("ready_low_before_swap", col_bus.col_ready, 0);
    vsync_edge();
    check("hold_swap", fs_count, 3);
    check("hold_ready_restored", col_bus.col_ready, 1);

    for (int i = 0; i < 16; i++) begin
      pix(tbl[i].x, tbl[i].y, 1, 0, 0);
      sb[sb.size() - 1].rgb = tbl[i].rgb;
    end
    pix(0, 0, 0, 1, 0);
    scan(20, 0, 479, 1);

    // Reset in the middle of a write frame
    pix(0, 300, 1, 1, 1);
    pix(0, 301, 1, 1, 0);
    fill_src(9'd100, 12'hF00);
    write_n(50);
    @(negedge clk);
    col_bus.col_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("midreset_rgb", rgb, 0);
    check("midreset_hsync", hsync, 0);
    check("midreset_vsync", vsync, 0);
    check("midreset_frame_start", frame_start, 0);
    check("midreset_col_ready", col_bus.col_ready, 1);
    col_bus.col_valid = 1'b0;
    sb.delete();
    wcnt = 0;
    m_valid = 0;
    m_vs_prev = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    scan(0, 0, 479, 60);
    vsync_edge();
    check("no_swap_after_reset", fs_count, 3);
    write_n(160);
    vsync_edge();
    check("swap_after_reset", fs_count, 4);
    scan(0, 0, 479, 1);
    pix(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
